// File: rtl/fifo_wr_rr_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
// Arbiter state encoding and the legal requester-count range.
package fifo_wr_rr_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    localparam int NR_MIN = 2;
    localparam int NR_MAX = 16;

    function automatic bit nr_legal(input int nr);
        return (nr >= NR_MIN) && (nr <= NR_MAX);
    endfunction

endpackage

// File: rtl/fifo_wr_rr_arb_if.sv
// Producer-side and FIFO-write-side handshake bundle of the arbiter.
// master is the arbiter; slave is the surrounding producers plus FIFO.
interface fifo_wr_rr_arb_if #(
    parameter int NR = 4,
    parameter int DW = 32
);
    localparam int IW = $clog2(NR);

    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_data;
    logic             fifo_valid;
    logic             fifo_ready;
    logic [DW-1:0]    fifo_data;
    logic [IW-1:0]    grant_id;
    logic             locked;

    modport master (
        input  req_valid, req_data, fifo_ready,
        output req_ready, fifo_valid, fifo_data, grant_id, locked
    );

    modport slave (
        output req_valid, req_data, fifo_ready,
        input  req_ready, fifo_valid, fifo_data, grant_id, locked
    );
endinterface

// File: rtl/fifo_wr_rr_arb_rr_pick.sv
// Rotate-priority encoder: first set bit of req scanning from ptr upward, wrapping at NR-1.
// Purely combinational; no handshake.
module rr_pick #(
    parameter int NR = 4,
    parameter int IW = $clog2(NR)
) (
    input  logic [NR-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);
    int            j;
    logic [IW-1:0] jj;

    // Scan from the far end so the candidate closest to ptr is written last and wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        jj  = '0;
        for (int k = NR - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NR) j = j - NR;
            jj = IW'(j);
            if (req[jj]) begin
                any = 1'b1;
                idx = jj;
            end
        end
    end
endmodule

// File: rtl/gen_dffr.sv
// Generic W-bit flop with asynchronous active-low clear to RV.
// One cycle latency; no handshake.
module gen_dffr #(
    parameter int           W  = 1,
    parameter logic [W-1:0] RV = '0
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) q <= RV;
        else       q <= d;
    end
endmodule

// File: rtl/fifo_wr_rr_arb.sv
// Round-robin share of one valid/ready FIFO write port among NR producers; zero-cycle valid/data path.
// On fifo_ready=0 the winner is locked until it transfers, so FIFO-side data never changes under valid.
module fifo_wr_rr_arb
    import fifo_wr_rr_arb_pkg::*;
#(
    parameter int NR = 4,
    parameter int DW = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    fifo_wr_rr_arb_if.master bus
);
    localparam int IW = $clog2(NR);

    if (!nr_legal(NR)) begin : g_bad_nr
        $error("fifo_wr_rr_arb: NR must be in 2..16");
    end

    arb_state_t    state_q, state_d;
    logic          state_raw;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] lock_q, lock_d;

    logic          pick_any;
    logic [IW-1:0] pick_idx;
    logic          gnt_vld;
    logic [IW-1:0] gnt_idx;
    logic          held;
    logic [NR-1:0] gnt_oh;
    logic [DW-1:0] data_mux;
    logic          out_vld;

    gen_dffr #(.W(1), .RV(1'b0)) u_state (
        .CLK(CLK), .RSTn(RSTn), .d(state_d), .q(state_raw)
    );
    assign state_q = arb_state_t'(state_raw);

    gen_dffr #(.W(IW), .RV('0)) u_ptr (
        .CLK(CLK), .RSTn(RSTn), .d(ptr_d), .q(ptr_q)
    );

    gen_dffr #(.W(IW), .RV('0)) u_lock (
        .CLK(CLK), .RSTn(RSTn), .d(lock_d), .q(lock_q)
    );

    rr_pick #(.NR(NR), .IW(IW)) u_pick (
        .req(bus.req_valid), .ptr(ptr_q), .any(pick_any), .idx(pick_idx)
    );

    // Explicit wrap keeps non-power-of-two NR from ever producing an index >= NR.
    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(NR - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        held    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_vld = 1'b1;
                    gnt_idx = pick_idx;
                    if (bus.fifo_ready) begin
                        ptr_d = ptr_inc(pick_idx);
                    end else begin
                        lock_d  = pick_idx;
                        state_d = ARB_HOLD;
                    end
                end
            end
            ARB_HOLD: begin
                held = 1'b1;
                if (bus.req_valid[lock_q]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = lock_q;
                    if (bus.fifo_ready) begin
                        ptr_d   = ptr_inc(lock_q);
                        state_d = ARB_IDLE;
                    end
                end else begin
                    // Producer dropped valid while locked: release without consuming a turn.
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, even with requests pending.
    assign out_vld = gnt_vld & RSTn;

    always_comb begin
        gnt_oh   = '0;
        data_mux = '0;
        for (int i = 0; i < NR; i++) begin
            gnt_oh[i] = out_vld && (gnt_idx == IW'(i));
            data_mux  = data_mux | (bus.req_data[i*DW +: DW] & {DW{gnt_oh[i]}});
        end
    end

    assign bus.fifo_valid = out_vld;
    assign bus.fifo_data  = data_mux;
    assign bus.grant_id   = out_vld ? gnt_idx : '0;
    assign bus.locked     = held & RSTn;
    assign bus.req_ready  = gnt_oh & {NR{bus.fifo_ready}};

endmodule
